// File: rtl/arb_rr_lock.sv
// arb_rr_lock: round-robin arbiter with packet lock and optional burst limit.
// The grant is held from IDLE pick until lst or LIMIT transfers, with zero-bubble handover.
module arb_rr_lock #(
    parameter int    WIDTH     = 4,
    parameter string DIRECTION = "LSB",
    parameter int    LIMIT     = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         req,
    input  logic [WIDTH-1:0]         lst,
    input  logic                     rdy,
    output logic                     vld,
    output logic [WIDTH-1:0]         gnt,
    output logic [$clog2(WIDTH)-1:0] idx,
    output logic                     bsy
);
    localparam int IW = $clog2(WIDTH);
    localparam int CW = LIMIT > 0 ? $clog2(LIMIT + 1) : 1;
    localparam bit MSB = DIRECTION == "MSB";
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] msk, msk_nxt, gnt_nxt, msk_upd, edge_m, oth, sel, sel_hand;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             trn, rel;

    function automatic logic [WIDTH-1:0] pick(input logic [WIDTH-1:0] r);
        logic [WIDTH-1:0] p;
        p = '0;
        for (int i = WIDTH - 1; i >= 0; i--) if (!MSB && r[i]) p = ONE << i;
        for (int i = 0; i < WIDTH; i++) if (MSB && r[i]) p = ONE << i;
        return p;
    endfunction

    function automatic logic [WIDTH-1:0] pick2(input logic [WIDTH-1:0] r, input logic [WIDTH-1:0] m);
        return |(r & m) ? pick(r & m) : pick(r);
    endfunction

    always_comb begin
        trn      = vld & rdy;
        rel      = trn & (|(lst & gnt) | ((LIMIT != 0) && (cnt == CW'(LIMIT - 1))));
        // Mask keeps only requesters past the winner; empty means the winner sat on the edge.
        edge_m   = MSB ? gnt - ONE : ~((gnt << 1) - ONE);
        msk_upd  = (edge_m == '0) ? '1 : edge_m;
        oth      = req & ~gnt;
        sel      = pick2(req, msk);
        sel_hand = pick2(oth, msk_upd);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            gnt   <= '0;
            msk   <= '1;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
            msk   <= msk_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        msk_nxt   = msk;
        cnt_nxt   = cnt;
        if (state == IDLE) begin
            if (|req) begin
                gnt_nxt   = sel;
                state_nxt = LOCK;
                cnt_nxt   = '0;
            end
        end else begin
            if (trn) cnt_nxt = cnt + CW'(1);
            if (rel) begin
                msk_nxt = msk_upd;
                cnt_nxt = '0;
                gnt_nxt = |oth ? sel_hand : '0;
                state_nxt = |oth ? LOCK : IDLE;
            end
        end
    end

    always_comb begin
        vld = |(req & gnt);
        bsy = state == LOCK;
        idx = '0;
        for (int i = 0; i < WIDTH; i++) if (gnt[i]) idx = IW'(i);
    end
endmodule

// File: tb/tb_arb_rr_lock.sv
// tb_arb_rr_lock: scenario tasks for arb_rr_lock using an expected-result queue.
// Three instances cover LSB/unlimited, LSB/LIMIT=2 and MSB/unlimited.
module tb_arb_rr_lock;
    typedef struct packed {
        logic [3:0] g;
        logic [1:0] i;
        logic       v;
        logic       b;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = '0;
    logic [3:0] lst = '0;
    logic       rdy = 1'b0;
    logic [3:0] gnt_a, gnt_l, gnt_m;
    logic [1:0] idx_a, idx_l, idx_m;
    logic       vld_a, vld_l, vld_m, bsy_a, bsy_l, bsy_m;
    int         n_chk = 0;
    int         n_fail = 0;
    exp_t       q[$];
    exp_t       e;

    always #5 clk = ~clk;

    arb_rr_lock #(.WIDTH(4), .DIRECTION("LSB"), .LIMIT(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .req(req), .lst(lst), .rdy(rdy),
        .vld(vld_a), .gnt(gnt_a), .idx(idx_a), .bsy(bsy_a));
    arb_rr_lock #(.WIDTH(4), .DIRECTION("LSB"), .LIMIT(2)) u_lim (
        .clk(clk), .rst_n(rst_n), .req(req), .lst(lst), .rdy(rdy),
        .vld(vld_l), .gnt(gnt_l), .idx(idx_l), .bsy(bsy_l));
    arb_rr_lock #(.WIDTH(4), .DIRECTION("MSB"), .LIMIT(0)) u_msb (
        .clk(clk), .rst_n(rst_n), .req(req), .lst(lst), .rdy(rdy),
        .vld(vld_m), .gnt(gnt_m), .idx(idx_m), .bsy(bsy_m));

    function automatic exp_t mk(input logic [3:0] g, input logic v, input logic b);
        exp_t x;
        x.g = g;
        x.v = v;
        x.b = b;
        case (g)
            4'b0010: x.i = 2'd1;
            4'b0100: x.i = 2'd2;
            4'b1000: x.i = 2'd3;
            default: x.i = 2'd0;
        endcase
        return x;
    endfunction

    task automatic do_reset;
        req = '0;
        lst = '0;
        rdy = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        req = 4'b1111;
        @(posedge clk);
        #1;
        n_chk++;
        if ({gnt_a, idx_a, vld_a, bsy_a} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_lsb: got %b want 00000000", {gnt_a, idx_a, vld_a, bsy_a});
        end
        n_chk++;
        if ({gnt_l, idx_l, vld_l, bsy_l} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_lim: got %b want 00000000", {gnt_l, idx_l, vld_l, bsy_l});
        end
        n_chk++;
        if ({gnt_m, idx_m, vld_m, bsy_m} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_msb: got %b want 00000000", {gnt_m, idx_m, vld_m, bsy_m});
        end
    endtask

    task automatic test_round_robin;
        do_reset();
        req = 4'b1010;
        lst = 4'b1111;
        rdy = 1'b1;
        for (int k = 0; k < 6; k++) q.push_back(mk((k % 2) ? 4'b1000 : 4'b0010, 1'b1, 1'b1));
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            e = q.pop_front();
            n_chk++;
            if ({gnt_a, idx_a, vld_a, bsy_a} !== e) begin
                n_fail++;
                $display("FAIL round_robin[%0d]: got %b want %b", k, {gnt_a, idx_a, vld_a, bsy_a}, e);
            end
        end
    endtask

    task automatic test_packet_lock;
        logic       rdy_t[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic       l0_t[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [3:0] g_t[7]   = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0001};
        do_reset();
        req = 4'b0011;
        for (int k = 0; k < 7; k++) begin
            rdy = rdy_t[k];
            lst = {2'b00, 1'b1, l0_t[k]};
            q.push_back(mk(g_t[k], 1'b1, 1'b1));
            @(posedge clk);
            #1;
            e = q.pop_front();
            n_chk++;
            if ({gnt_a, idx_a, vld_a, bsy_a} !== e) begin
                n_fail++;
                $display("FAIL packet_lock[%0d]: got %b want %b", k, {gnt_a, idx_a, vld_a, bsy_a}, e);
            end
        end
    endtask

    task automatic test_burst_limit;
        logic [3:0] g_t[7] = '{4'b0001, 4'b0001, 4'b0100, 4'b0100, 4'b0001, 4'b0001, 4'b0100};
        do_reset();
        req = 4'b0101;
        lst = 4'b0000;
        rdy = 1'b1;
        for (int k = 0; k < 7; k++) q.push_back(mk(g_t[k], 1'b1, 1'b1));
        for (int k = 0; k < 7; k++) begin
            @(posedge clk);
            #1;
            e = q.pop_front();
            n_chk++;
            if ({gnt_l, idx_l, vld_l, bsy_l} !== e) begin
                n_fail++;
                $display("FAIL burst_limit[%0d]: got %b want %b", k, {gnt_l, idx_l, vld_l, bsy_l}, e);
            end
        end
    endtask

    task automatic test_msb;
        logic [3:0] g_t[5] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};
        do_reset();
        req = 4'b1111;
        lst = 4'b1111;
        rdy = 1'b1;
        for (int k = 0; k < 5; k++) q.push_back(mk(g_t[k], 1'b1, 1'b1));
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            e = q.pop_front();
            n_chk++;
            if ({gnt_m, idx_m, vld_m, bsy_m} !== e) begin
                n_fail++;
                $display("FAIL msb_order[%0d]: got %b want %b", k, {gnt_m, idx_m, vld_m, bsy_m}, e);
            end
        end
    endtask

    task automatic test_edge_drop;
        logic [3:0] r_t[6] = '{4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0001};
        logic [3:0] l_t[6] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0000};
        logic [3:0] g_t[6] = '{4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0001};
        logic       v_t[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic       b_t[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        do_reset();
        rdy = 1'b1;
        for (int k = 0; k < 6; k++) begin
            req = r_t[k];
            lst = l_t[k];
            q.push_back(mk(g_t[k], v_t[k], b_t[k]));
            @(posedge clk);
            #1;
            e = q.pop_front();
            n_chk++;
            if ({gnt_a, idx_a, vld_a, bsy_a} !== e) begin
                n_fail++;
                $display("FAIL edge_drop[%0d]: got %b want %b", k, {gnt_a, idx_a, vld_a, bsy_a}, e);
            end
        end
    endtask

    task automatic test_async_reset;
        do_reset();
        req = 4'b0100;
        lst = 4'b0000;
        rdy = 1'b1;
        q.push_back(mk(4'b0100, 1'b1, 1'b1));
        @(posedge clk);
        #1;
        e = q.pop_front();
        n_chk++;
        if ({gnt_a, idx_a, vld_a, bsy_a} !== e) begin
            n_fail++;
            $display("FAIL async_pre: got %b want %b", {gnt_a, idx_a, vld_a, bsy_a}, e);
        end
        #2 rst_n = 1'b0;
        q.push_back(mk(4'b0000, 1'b0, 1'b0));
        #1;
        e = q.pop_front();
        n_chk++;
        if ({gnt_a, idx_a, vld_a, bsy_a} !== e) begin
            n_fail++;
            $display("FAIL async_drop: got %b want %b", {gnt_a, idx_a, vld_a, bsy_a}, e);
        end
        @(negedge clk);
        rst_n = 1'b1;
        req = 4'b0110;
        q.push_back(mk(4'b0010, 1'b1, 1'b1));
        @(posedge clk);
        #1;
        e = q.pop_front();
        n_chk++;
        if ({gnt_a, idx_a, vld_a, bsy_a} !== e) begin
            n_fail++;
            $display("FAIL async_restart: got %b want %b", {gnt_a, idx_a, vld_a, bsy_a}, e);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_packet_lock();
        test_burst_limit();
        test_msb();
        test_edge_drop();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/arb_rr_lock.md
Name: arb_rr_lock

Overview:
- Round-robin arbiter that shares one downstream resource among WIDTH requesters.
- Uses a masked two-level priority-to-one-hot selection: masked requests first, then all requests.
- The winner keeps a registered grant until its packet ends (lst) or a burst limit is reached.
- Sits in front of shared buses or ports and drives the valid/ready handshake toward the resource.

Parameters:
- WIDTH, 4, number of requesters (≥2).
- DIRECTION, "LSB", "LSB": search from the rightmost bit upward. "MSB": search from the leftmost bit downward.
- LIMIT, 0, maximum transfers per grant; 0 means unlimited (release only on lst).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req  input  WIDTH  per-requester request; doubles as per-requester data valid.
- lst  input  WIDTH  per-requester last-transfer flag; sampled only for the granted requester.
- rdy  input  1  downstream ready.
- vld  output  1  downstream valid, equal to |(req & gnt).
- gnt  output  WIDTH  registered one-hot grant, or zero.
- idx  output  $clog2(WIDTH)  binary index of gnt; 0 when gnt is zero.
- bsy  output  1  high while in state LOCK.

Behaviour:
- Reset (asynchronous, rst_n low), all taking effect immediately:
  - state = IDLE
  - gnt = 0, idx = 0, bsy = 0
  - msk = all-ones
  - cnt = 0
- trn = vld & rdy, which is one transfer. rel = trn & (|(lst & gnt) | (LIMIT≠0 & cnt==LIMIT-1)).
- Selection, combinational:
  - sel = one-hot priority pick of (req & msk) if that is nonzero, else of req.
  - "Priority" follows DIRECTION: lowest index for LSB, highest index for MSB.
- State IDLE:
  - If |req: next gnt = sel, state -> LOCK, cnt = 0.
  - Request-to-grant latency is 1 cycle.
  - No transfer is possible in IDLE, because gnt = 0 forces vld = 0.
- State LOCK:
  - gnt is held constant.
  - On each trn, cnt increments.
  - On rel:
    - msk update for LSB: bits strictly above the winner. For MSB: bits strictly below the winner.
    - If msk becomes 0 (winner was at the edge), it reloads all-ones.
    - If |(req & ~gnt) in the same cycle: gnt = sel, computed with the updated-mask rule applied to the current winner and excluding the current winner. State stays LOCK and cnt = 0 (zero-bubble handover).
    - Otherwise: gnt = 0, state -> IDLE.
  - Requester dropping req while granted (no rel):
    - vld falls, grant is held, no timeout.
    - The requester re-raising req resumes the same packet.
- Fairness:
  - After requester i is served, every other pending requester is served before i again.
  - With all WIDTH requesting single-transfer packets, grants cycle 0,1,2,…,WIDTH-1,0 for LSB and reverse order for MSB.
- LIMIT:
  - When cnt == LIMIT-1 and trn occurs, the grant is released even without lst.
  - The remainder of that packet competes again as a new request.
  - cnt width is $clog2(LIMIT+1); it is unused when LIMIT = 0.
- Simultaneous events:
  - lst and a limit hit in the same cycle count as a single release.
  - rdy low with lst high causes no release.
  - lst on non-granted requesters is ignored.
- Reset mid-packet: the grant drops at once and the pointer returns to the reset mask. Downstream must discard the partial packet.
- gnt and idx are always consistent. gnt is never multi-hot.

Test Plan:
- Reset, DIRECTION=LSB, WIDTH=4, rdy=1: req=4'b1010 with lst=4'b1111 held → gnt=0010 one cycle later, then 1000, then 0010, …; vld=1 on every LOCK cycle; no idle gap between grants.
- Packet lock: req=4'b0011, lst[0] high only on the 3rd transfer of requester 0 → gnt=0001 for exactly 3 trn cycles, then gnt=0010 the next cycle; rdy toggled 1,0,1,0,1 stretches the hold with no early release.
- Burst limit: LIMIT=2, req=4'b0101, lst=0 → gnt alternates 0001,0100,0001 every 2 transfers; cnt resets on each handover.
- MSB direction: DIRECTION="MSB", req=4'b1111, lst=4'b1111, rdy=1 → gnt sequence 1000,0100,0010,0001,1000; idx sequence 3,2,1,0,3.
- Edge and drop: a single requester, req=4'b1000 → gnt=1000. Its req then drops for 3 cycles → vld=0, gnt stays 1000. It returns with lst → release, state IDLE, gnt=0 with msk reloaded to all-ones; the next req=4'b0001 is granted.
- Asynchronous reset during LOCK (gnt=0100) → gnt=0, bsy=0 immediately without a clock edge. After release, req=4'b0110 → gnt=0010 (mask restarted).
